// File: rtl/qmac_seq.sv
// Window sequencer/accumulator behind the serial sign-magnitude multiplier:
// issues K operand pairs, sums the products and emits one saturated sign-magnitude result.
module qmac_seq #(
    parameter int Q = 15,
    parameter int N = 32,
    parameter int K = 9,
    parameter int G = 8
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_in_valid,
    output logic         o_in_ready,
    input  logic [N-1:0] i_data,
    input  logic [N-1:0] i_weight,
    output logic [N-1:0] o_mul_multiplicand,
    output logic [N-1:0] o_mul_multiplier,
    output logic         o_mul_start,
    input  logic [N-1:0] i_mul_result,
    input  logic         i_mul_complete,
    input  logic         i_mul_overflow,
    output logic         o_out_valid,
    input  logic         i_out_ready,
    output logic [N-1:0] o_out_data,
    output logic         o_out_overflow
);

    localparam int AW = N + G;
    localparam logic signed [AW-1:0] MAX_POS = {{(G + 1){1'b0}}, {(N - 1){1'b1}}};
    localparam logic signed [AW-1:0] MAX_NEG = -MAX_POS;
    localparam logic [7:0] K_LAST = 8'(K);

    if (Q < 1 || Q > N - 2) begin : g_bad_q
        $error("qmac_seq: Q must leave an integer bit and a sign bit");
    end
    if (K < 1 || K > 255 || K > (1 << G)) begin : g_bad_k
        $error("qmac_seq: K must be 1..255 and no larger than 2**G");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_WAIT_BUSY,
        S_WAIT_DONE,
        S_ACCUM,
        S_OUTPUT
    } state_t;

    state_t r_state;
    state_t w_state_next;

    logic [N-1:0]          r_mcand;
    logic [N-1:0]          r_mplier;
    logic [N-1:0]          r_result;
    logic signed [AW-1:0]  r_acc;
    logic [7:0]            r_count;
    logic                  r_sticky;

    logic                  w_in_ready;
    logic                  w_start;
    logic                  w_out_valid;
    logic [7:0]            w_count_inc;
    logic signed [AW-1:0]  w_prod_mag;
    logic signed [AW-1:0]  w_prod;
    logic signed [AW-1:0]  w_acc_sum;
    logic                  w_sat_pos;
    logic                  w_sat_neg;
    logic                  w_acc_neg;
    logic [N-2:0]          w_mag;
    logic [N-2:0]          w_out_mag;
    logic                  w_out_sign;

    assign w_count_inc = r_count + 8'd1;

    // Negative zero from the multiplier negates to zero, so it adds nothing.
    assign w_prod_mag = {{(G + 1){1'b0}}, r_result[N-2:0]};
    assign w_prod     = r_result[N-1] ? -w_prod_mag : w_prod_mag;
    assign w_acc_sum  = r_acc + w_prod;

    always_comb begin
        w_state_next = r_state;
        w_in_ready   = 1'b0;
        w_start      = 1'b0;
        w_out_valid  = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_in_ready = 1'b1;
                if (i_in_valid) w_state_next = S_START;
            end
            S_START: begin
                w_start      = 1'b1;
                w_state_next = S_WAIT_BUSY;
            end
            // complete is still high from the previous product here; wait for it to drop.
            S_WAIT_BUSY: begin
                if (!i_mul_complete) w_state_next = S_WAIT_DONE;
            end
            S_WAIT_DONE: begin
                if (i_mul_complete) w_state_next = S_ACCUM;
            end
            S_ACCUM: begin
                w_state_next = (w_count_inc == K_LAST) ? S_OUTPUT : S_IDLE;
            end
            S_OUTPUT: begin
                w_out_valid = 1'b1;
                if (i_out_ready) w_state_next = S_IDLE;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_mcand  <= '0;
            r_mplier <= '0;
            r_result <= '0;
            r_acc    <= '0;
            r_count  <= '0;
            r_sticky <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_in_valid) begin
                        r_mcand  <= i_data;
                        r_mplier <= i_weight;
                    end
                end
                S_WAIT_DONE: begin
                    if (i_mul_complete) begin
                        r_result <= i_mul_result;
                        r_sticky <= r_sticky | i_mul_overflow;
                    end
                end
                S_ACCUM: begin
                    r_acc   <= w_acc_sum;
                    r_count <= w_count_inc;
                end
                S_OUTPUT: begin
                    if (i_out_ready) begin
                        r_acc    <= '0;
                        r_count  <= '0;
                        r_sticky <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    // Within range the low N-1 bits of -acc equal |acc|, so negating only those bits suffices.
    assign w_sat_pos  = (r_acc > MAX_POS);
    assign w_sat_neg  = (r_acc < MAX_NEG);
    assign w_acc_neg  = r_acc[AW-1];
    assign w_mag      = w_acc_neg ? (~r_acc[N-2:0] + 1'b1) : r_acc[N-2:0];
    assign w_out_mag  = (w_sat_pos || w_sat_neg) ? '1 : w_mag;
    assign w_out_sign = w_sat_neg || (!w_sat_pos && w_acc_neg);

    assign o_in_ready         = w_in_ready;
    assign o_mul_start        = w_start;
    assign o_mul_multiplicand = r_mcand;
    assign o_mul_multiplier   = r_mplier;
    assign o_out_valid        = w_out_valid;
    assign o_out_data         = w_out_valid ? {w_out_sign, w_out_mag} : '0;
    assign o_out_overflow     = w_out_valid & (r_sticky | w_sat_pos | w_sat_neg);

endmodule

// File: tb/tb_qmac_seq.sv
// Bench for qmac_seq: behavioural serial multiplier with random latency, directed windows,
// randomized windows against an arithmetic reference, back-pressure and mid-window reset.
module tb_qmac_seq;

    localparam int Q = 15;
    localparam int N = 32;
    localparam int K = 9;
    localparam int G = 8;
    localparam longint MAXL = 64'sd2147483647;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [N-1:0]  data;
    logic [N-1:0]  weight;
    logic [N-1:0]  mcand;
    logic [N-1:0]  mplier;
    logic          mul_start;
    logic [N-1:0]  mul_result = '0;
    logic          mul_complete = 1'b1;
    logic          mul_overflow = 1'b0;
    logic          out_valid;
    logic          out_ready;
    logic [N-1:0]  out_data;
    logic          out_overflow;

    int tests = 0;
    int fails = 0;

    logic [N-1:0] win_a[$];
    logic [N-1:0] win_b[$];
    logic         win_f[$];
    logic [N-1:0] exp_q[$];
    logic         exp_ovf_q[$];

    logic         mul_force = 1'b0;
    int           mul_cnt = 0;
    logic [N-1:0] mul_pend = '0;
    logic         mul_pend_ovf = 1'b0;

    always #5 clk = ~clk;

    qmac_seq #(.Q(Q), .N(N), .K(K), .G(G)) dut (
        .i_clk              (clk),
        .i_rst              (rst),
        .i_in_valid         (in_valid),
        .o_in_ready         (in_ready),
        .i_data             (data),
        .i_weight           (weight),
        .o_mul_multiplicand (mcand),
        .o_mul_multiplier   (mplier),
        .o_mul_start        (mul_start),
        .i_mul_result       (mul_result),
        .i_mul_complete     (mul_complete),
        .i_mul_overflow     (mul_overflow),
        .o_out_valid        (out_valid),
        .i_out_ready        (out_ready),
        .o_out_data         (out_data),
        .o_out_overflow     (out_overflow)
    );

    // Sign-magnitude Q-format product: magnitude truncated, overflow when it exceeds N-1 bits.
    function automatic logic [N-1:0] mul_res(input logic [N-1:0] a, input logic [N-1:0] b);
        longint unsigned m;
        m = (longint'(a[N-2:0]) * longint'(b[N-2:0])) >> Q;
        return {a[N-1] ^ b[N-1], m[N-2:0]};
    endfunction

    function automatic logic mul_ovf(input logic [N-1:0] a, input logic [N-1:0] b);
        longint unsigned m;
        m = (longint'(a[N-2:0]) * longint'(b[N-2:0])) >> Q;
        return (m > 64'h7FFF_FFFF);
    endfunction

    // Multiplier model: complete drops the edge after start and returns after a random delay.
    always @(posedge clk) begin
        if (mul_start) begin
            mul_pend     <= mul_res(mcand, mplier);
            mul_pend_ovf <= mul_ovf(mcand, mplier) | mul_force;
            mul_cnt      <= $urandom_range(1, 6);
            mul_complete <= 1'b0;
        end else if (mul_cnt > 0) begin
            mul_cnt <= mul_cnt - 1;
            if (mul_cnt == 1) begin
                mul_complete <= 1'b1;
                mul_result   <= mul_pend;
                mul_overflow <= mul_pend_ovf;
            end
        end
    end

    // Reference: signed sum of all window products, then clamp to +/-(2^(N-1)-1).
    function automatic logic [N:0] ref_window();
        longint sum = 0;
        logic   ovf = 1'b0;
        logic [N-1:0] r;
        longint mag;
        foreach (win_a[i]) begin
            r   = mul_res(win_a[i], win_b[i]);
            mag = longint'(r[N-2:0]);
            sum = r[N-1] ? sum - mag : sum + mag;
            ovf = ovf | mul_ovf(win_a[i], win_b[i]) | win_f[i];
        end
        if (sum > MAXL) return {1'b1, 32'h7FFF_FFFF};
        if (sum < -MAXL) return {1'b1, 32'hFFFF_FFFF};
        if (sum < 0) return {ovf, 1'b1, 31'(-sum)};
        return {ovf, 1'b0, 31'(sum)};
    endfunction

    task automatic chk(input string tag, input logic [N-1:0] obs, input logic [N-1:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic clear_win();
        win_a.delete();
        win_b.delete();
        win_f.delete();
    endtask

    task automatic push_pair(input logic [N-1:0] a, input logic [N-1:0] b, input logic f);
        win_a.push_back(a);
        win_b.push_back(b);
        win_f.push_back(f);
    endtask

    task automatic fill_const(input logic [N-1:0] a, input logic [N-1:0] b);
        clear_win();
        for (int i = 0; i < K; i++) push_pair(a, b, 1'b0);
    endtask

    task automatic send_pair(input logic [N-1:0] a, input logic [N-1:0] b, input logic f);
        int n = 0;
        @(negedge clk);
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("in_ready", {31'd0, in_ready}, 32'd1);
        data      = a;
        weight    = b;
        mul_force = f;
        in_valid  = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic collect(input logic bp, input int hold);
        int n = 0;
        logic [N-1:0] expd;
        logic expo;
        logic rdy;
        expd = exp_q.pop_front();
        expo = exp_ovf_q.pop_front();
        @(negedge clk);
        while (!out_valid && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk("out_valid", {31'd0, out_valid}, 32'd1);
        chk("out_data", out_data, expd);
        chk("out_overflow", {31'd0, out_overflow}, {31'd0, expo});
        for (int h = 0; h < hold; h++) begin
            out_ready = 1'b0;
            @(negedge clk);
            chk("hold_data", out_data, expd);
            chk("hold_in_ready", {31'd0, in_ready}, 32'd0);
            chk("hold_valid", {31'd0, out_valid}, 32'd1);
        end
        for (int t = 0; t < 10; t++) begin
            rdy = (t == 9) || !bp || ($urandom_range(0, 1) == 1);
            out_ready = rdy;
            @(posedge clk);
            #1;
            if (rdy) break;
            chk("bp_data", out_data, expd);
            chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
            @(negedge clk);
        end
        chk("valid_drop", {31'd0, out_valid}, 32'd0);
        out_ready = 1'b0;
    endtask

    task automatic run_window(input logic [N-1:0] expd, input logic expo, input logic bp,
                              input int hold);
        exp_q.push_back(expd);
        exp_ovf_q.push_back(expo);
        foreach (win_a[i]) send_pair(win_a[i], win_b[i], win_f[i]);
        collect(bp, hold);
    endtask

    function automatic logic [N-1:0] rand_op();
        logic [N-1:0] m;
        case ($urandom_range(0, 3))
            0: m = 32'($urandom_range(0, 32'h0003_FFFF));
            1: m = $urandom;
            2: m = 32'd0;
            default: m = 32'($urandom_range(0, 32'h00FF_FFFF));
        endcase
        return {1'($urandom_range(0, 1)), m[N-2:0]};
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [N:0] r;
        int n;
        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        data = '0;
        weight = '0;
        repeat (3) @(negedge clk);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_start", {31'd0, mul_start}, 32'd0);
        chk("rst_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_data", out_data, 32'd0);
        chk("rst_ovf", {31'd0, out_overflow}, 32'd0);
        chk("rst_mcand", mcand, 32'd0);
        chk("rst_mplier", mplier, 32'd0);
        rst = 1'b0;

        // 9 x (1.0 * 1.0) = 9.0
        fill_const(32'h0000_8000, 32'h0000_8000);
        run_window(32'h0004_8000, 1'b0, 1'b0, 0);

        // 4 x (+2.0*0.5) + 5 x (-2.0*0.5) = -1.0
        clear_win();
        for (int i = 0; i < 4; i++) push_pair(32'h0001_0000, 32'h0000_4000, 1'b0);
        for (int i = 0; i < 5; i++) push_pair(32'h8001_0000, 32'h0000_4000, 1'b0);
        run_window(32'h8000_8000, 1'b0, 1'b0, 0);

        // +1 - 1 cancels to positive zero
        clear_win();
        push_pair(32'h0000_8000, 32'h0000_8000, 1'b0);
        push_pair(32'h8000_8000, 32'h0000_8000, 1'b0);
        for (int i = 0; i < K - 2; i++) push_pair(32'h0, 32'h0, 1'b0);
        run_window(32'h0000_0000, 1'b0, 1'b0, 0);

        // Negative-zero operand yields negative-zero products
        clear_win();
        push_pair(32'h0000_8000, 32'h0000_8000, 1'b0);
        push_pair(32'h8000_8000, 32'h0000_8000, 1'b0);
        for (int i = 0; i < K - 2; i++) push_pair(32'h8000_0000, 32'h0000_8000, 1'b0);
        run_window(32'h0000_0000, 1'b0, 1'b0, 0);

        // Positive and negative saturation
        fill_const(32'h3FFF_8000, 32'h0001_0000);
        run_window(32'h7FFF_FFFF, 1'b1, 1'b0, 0);
        fill_const(32'hBFFF_8000, 32'h0001_0000);
        run_window(32'hFFFF_FFFF, 1'b1, 1'b0, 0);

        // Multiplier overflow is sticky for its window only
        fill_const(32'h0000_8000, 32'h0000_8000);
        win_f[3] = 1'b1;
        run_window(32'h0004_8000, 1'b1, 1'b0, 0);
        fill_const(32'h0000_8000, 32'h0000_8000);
        run_window(32'h0004_8000, 1'b0, 1'b0, 0);

        // 20 cycles of back-pressure
        fill_const(32'h0001_0000, 32'h0000_C000);
        run_window(32'h000D_8000, 1'b0, 1'b0, 20);

        // Reset during the 5th product's WAIT_DONE
        for (int i = 0; i < 5; i++) send_pair(32'h0000_8000, 32'h0000_8000, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("mid_rst_start", {31'd0, mul_start}, 32'd0);
        chk("mid_rst_valid", {31'd0, out_valid}, 32'd0);
        chk("mid_rst_data", out_data, 32'd0);
        chk("mid_rst_mcand", mcand, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        n = 0;
        while (!mul_complete && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("mul_idle", {31'd0, mul_complete}, 32'd1);
        fill_const(32'h0000_8000, 32'h0000_8000);
        run_window(32'h0004_8000, 1'b0, 1'b0, 0);

        // Randomized windows against the reference
        for (int w = 0; w < 14; w++) begin
            clear_win();
            for (int i = 0; i < K; i++)
                push_pair(rand_op(), rand_op(), ($urandom_range(0, 15) == 0));
            r = ref_window();
            run_window(r[N-1:0], r[N], 1'b1, 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
